// File: rtl/sfx_sequencer.sv
// Sound-effect sequencer: plays programmable (note, duration) lists from a
// writable table. Effects are started by trigger rising edges and arbitrated
// by fixed priority, where a lower index wins and can pre-empt a playing
// effect. The duration tick is generated internally from clk.
module sfx_sequencer #(
  parameter int NOTE_W    = 6,
  parameter int LEN_W     = 6,
  parameter int MAX_NOTES = 8,
  parameter int NUM_SFX   = 4,
  parameter int TICK_DIV  = 262144
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enabled,
  input  logic [NUM_SFX-1:0]           trigger,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_SFX)-1:0]   cfg_sfx,
  input  logic [$clog2(MAX_NOTES)-1:0] cfg_idx,
  input  logic [NOTE_W-1:0]            cfg_note,
  input  logic [LEN_W-1:0]             cfg_len,
  output logic [NOTE_W-1:0]            note,
  output logic                         busy,
  output logic [$clog2(NUM_SFX)-1:0]   active_id,
  output logic                         done
);

  localparam int SW = $clog2(NUM_SFX);
  localparam int IW = $clog2(MAX_NOTES);
  localparam int CW = $clog2(TICK_DIV);
  localparam int EW = NOTE_W + LEN_W;

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  state_t            state_q, state_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic [SW-1:0]     id_q, id_d;
  logic              done_q, done_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [NUM_SFX-1:0] trig_q;

  logic [EW-1:0] tbl [NUM_SFX*MAX_NOTES];

  logic [NUM_SFX-1:0] rise;
  logic [SW-1:0]      winner;
  logic               any_rise, tick, last_tick, at_last, end_now, start_ok;
  logic [EW-1:0]      start_ent, next_ent;

  // Effect table: plain write port, never cleared so programs survive reset
  always_ff @(posedge clk) begin
    if (cfg_we) tbl[{cfg_sfx, cfg_idx}] <= {cfg_note, cfg_len};
  end

  // State register plus trigger history; history tracks even while disabled
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      note_q  <= '0;
      id_q    <= '0;
      done_q  <= 1'b0;
      ptr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      trig_q  <= '0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      id_q    <= id_d;
      done_q  <= done_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      trig_q  <= trigger;
    end
  end

  // Next state: tick/advance of the playing effect, then a start overrides it
  always_comb begin
    rise     = trigger & ~trig_q;
    any_rise = |rise;
    winner   = '0;
    for (int i = NUM_SFX - 1; i >= 0; i--) begin
      if (rise[i]) winner = SW'(i);
    end
    start_ent = tbl[{winner, {IW{1'b0}}}];
    next_ent  = tbl[{id_q, ptr_q + IW'(1)}];
    tick      = (state_q == S_PLAY) && (cnt_q == CW'(TICK_DIV - 1));
    last_tick = tick && (rem_q == LEN_W'(1));
    at_last   = (ptr_q == IW'(MAX_NOTES - 1));
    end_now   = last_tick && (at_last || (next_ent[LEN_W-1:0] == '0));
    start_ok  = any_rise && ((state_q == S_IDLE) || (winner < id_q) || end_now);

    state_d = state_q;
    note_d  = note_q;
    id_d    = id_q;
    done_d  = 1'b0;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;

    if (!enabled) begin
      state_d = S_IDLE;
      note_d  = '0;
      id_d    = '0;
      cnt_d   = '0;
    end else begin
      if (state_q == S_PLAY) begin
        if (!tick) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = '0;
          if (!last_tick) begin
            rem_d = rem_q - LEN_W'(1);
          end else if (end_now) begin
            state_d = S_IDLE;
            note_d  = '0;
            id_d    = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d  = ptr_q + IW'(1);
            note_d = next_ent[EW-1:LEN_W];
            rem_d  = next_ent[LEN_W-1:0];
          end
        end
      end
      if (start_ok) begin
        ptr_d = '0;
        cnt_d = '0;
        if (start_ent[LEN_W-1:0] != '0) begin
          state_d = S_PLAY;
          note_d  = start_ent[EW-1:LEN_W];
          id_d    = winner;
          rem_d   = start_ent[LEN_W-1:0];
        end else begin
          state_d = S_IDLE;
          note_d  = '0;
          id_d    = '0;
        end
      end
    end
  end

  assign note      = note_q;
  assign busy      = (state_q == S_PLAY);
  assign active_id = id_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Self-checking bench for sfx_sequencer: explicit vector table, hand-written
// corner sequences, and randomized traffic against a cycle-count model.
module tb_sfx_sequencer;

  localparam int NOTE_W = 6, LEN_W = 6, MAX_NOTES = 8, NUM_SFX = 4, TICK_DIV = 4;

  logic       clk, reset, enabled, cfg_we;
  logic [3:0] trigger;
  logic [1:0] cfg_sfx;
  logic [2:0] cfg_idx;
  logic [5:0] cfg_note, cfg_len;
  logic [5:0] note;
  logic       busy, done;
  logic [1:0] active_id;

  sfx_sequencer #(
    .NOTE_W(NOTE_W), .LEN_W(LEN_W), .MAX_NOTES(MAX_NOTES),
    .NUM_SFX(NUM_SFX), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .reset(reset), .enabled(enabled), .trigger(trigger),
    .cfg_we(cfg_we), .cfg_sfx(cfg_sfx), .cfg_idx(cfg_idx),
    .cfg_note(cfg_note), .cfg_len(cfg_len),
    .note(note), .busy(busy), .active_id(active_id), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: each entry lasts len*TICK_DIV cycles, counted directly
  int   note_tab [NUM_SFX][MAX_NOTES];
  int   len_tab  [NUM_SFX][MAX_NOTES];
  int   m_note = 0, m_id = 0, m_pos = 0, m_left = 0;
  bit   m_busy = 0, m_done = 0;
  logic [3:0] m_trig = '0;

  function automatic void modelStep(input logic rst, input logic en, input logic [3:0] trg,
                                    input logic we, input logic [1:0] sf, input logic [2:0] ix,
                                    input logic [5:0] nt, input logic [5:0] ln);
    logic [3:0] r;
    bit nat, was_busy;
    int was_id, w;
    nat = 0;
    m_done = 0;
    if (rst) begin
      m_busy = 0; m_note = 0; m_id = 0; m_trig = '0;
    end else begin
      r = trg & ~m_trig;
      m_trig = trg;
      if (!en) begin
        m_busy = 0; m_note = 0; m_id = 0;
      end else begin
        was_busy = m_busy;
        was_id = m_id;
        if (m_busy) begin
          m_left--;
          if (m_left == 0) begin
            m_pos++;
            if (m_pos >= MAX_NOTES || len_tab[m_id][m_pos] == 0) begin
              nat = 1; m_busy = 0; m_note = 0; m_id = 0;
            end else begin
              m_note = note_tab[m_id][m_pos];
              m_left = len_tab[m_id][m_pos] * TICK_DIV;
            end
          end
        end
        w = -1;
        for (int i = NUM_SFX - 1; i >= 0; i--) if (r[i]) w = i;
        if (w >= 0 && (!was_busy || w < was_id || nat)) begin
          m_pos = 0;
          if (len_tab[w][0] != 0) begin
            m_busy = 1; m_note = note_tab[w][0]; m_id = w;
            m_left = len_tab[w][0] * TICK_DIV;
          end else begin
            m_busy = 0; m_note = 0; m_id = 0;
          end
        end
        m_done = nat;
      end
    end
    if (we) begin
      note_tab[sf][ix] = int'(nt);
      len_tab[sf][ix]  = int'(ln);
    end
  endfunction

  task automatic checkOutput(input string name, input logic [5:0] en_note, input logic en_busy,
                             input logic [1:0] en_id, input logic en_done);
    checks++;
    if (note !== en_note || busy !== en_busy || active_id !== en_id || done !== en_done) begin
      failures++;
      $display("[TB] FAIL %s: got note=%0d busy=%0d id=%0d done=%0d, want note=%0d busy=%0d id=%0d done=%0d",
               name, note, busy, active_id, done, en_note, en_busy, en_id, en_done);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic [3:0] trg,
                               input logic we, input logic [1:0] sf, input logic [2:0] ix,
                               input logic [5:0] nt, input logic [5:0] ln);
    @(negedge clk);
    reset = rst; enabled = en; trigger = trg; cfg_we = we;
    cfg_sfx = sf; cfg_idx = ix; cfg_note = nt; cfg_len = ln;
    @(posedge clk);
    modelStep(rst, en, trg, we, sf, ix, nt, ln);
    #1;
    cyc++;
    checkOutput($sformatf("model cyc %0d", cyc), 6'(m_note), m_busy, 2'(m_id), m_done);
  endtask

  task automatic step(input logic [3:0] trg);
    applyStimulus(1'b0, 1'b1, trg, 1'b0, 2'd0, 3'd0, 6'd0, 6'd0);
  endtask

  task automatic writeEntry(input logic [1:0] sf, input logic [2:0] ix,
                            input logic [5:0] nt, input logic [5:0] ln);
    applyStimulus(1'b0, 1'b1, 4'd0, 1'b1, sf, ix, nt, ln);
  endtask

  typedef struct {
    logic [3:0] trig;
    logic [5:0] note;
    logic       busy;
    logic [1:0] id;
    logic       done;
    int         reps;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [3:0] t, input logic [5:0] n, input logic b,
                                 input logic [1:0] i, input logic d, input int r);
    vec_t v;
    v.trig = t; v.note = n; v.busy = b; v.id = i; v.done = d; v.reps = r;
    vecs.push_back(v);
  endfunction

  // Main sequence: reset, program, vectors, corner cases, random traffic
  initial begin
    logic       r_en;
    logic [3:0] r_trig;
    reset = 1'b1; enabled = 1'b1; trigger = '0; cfg_we = 1'b0;
    cfg_sfx = '0; cfg_idx = '0; cfg_note = '0; cfg_len = '0;
    for (int s = 0; s < NUM_SFX; s++)
      for (int e = 0; e < MAX_NOTES; e++) begin
        note_tab[s][e] = 0; len_tab[s][e] = 0;
      end

    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b1, 4'd0, 1'b0, 2'd0, 3'd0, 6'd0, 6'd0);
    checkOutput("reset", 6'd0, 1'b0, 2'd0, 1'b0);

    for (int s = 0; s < NUM_SFX; s++)
      for (int e = 0; e < MAX_NOTES; e++) writeEntry(2'(s), 3'(e), 6'd0, 6'd0);
    writeEntry(2'd1, 3'd0, 6'd5, 6'd2);
    writeEntry(2'd1, 3'd1, 6'd9, 6'd1);
    for (int e = 0; e < MAX_NOTES; e++) writeEntry(2'd0, 3'(e), 6'(e + 1), 6'd1);
    writeEntry(2'd2, 3'd0, 6'd12, 6'd3);
    writeEntry(2'd2, 3'd1, 6'd13, 6'd3);
    writeEntry(2'd3, 3'd0, 6'd7, 6'd0);

    addVec(4'b0010, 6'd5, 1, 2'd1, 0, 1);
    addVec(4'b0000, 6'd5, 1, 2'd1, 0, 7);
    addVec(4'b0000, 6'd9, 1, 2'd1, 0, 4);
    addVec(4'b0000, 6'd0, 0, 2'd0, 1, 1);
    addVec(4'b0000, 6'd0, 0, 2'd0, 0, 2);
    addVec(4'b0001, 6'd1, 1, 2'd0, 0, 1);
    addVec(4'b0000, 6'd1, 1, 2'd0, 0, 3);
    for (int k = 2; k <= 8; k++) addVec(4'b0000, 6'(k), 1, 2'd0, 0, 4);
    addVec(4'b0000, 6'd0, 0, 2'd0, 1, 1);
    addVec(4'b0000, 6'd0, 0, 2'd0, 0, 2);
    addVec(4'b1000, 6'd0, 0, 2'd0, 0, 3);
    addVec(4'b0000, 6'd0, 0, 2'd0, 0, 2);

    foreach (vecs[v])
      for (int r = 0; r < vecs[v].reps; r++) begin
        step(vecs[v].trig);
        checkOutput($sformatf("vec %0d rep %0d", v, r),
                    vecs[v].note, vecs[v].busy, vecs[v].id, vecs[v].done);
      end

    // Pre-emption by a lower index, then a higher index is ignored
    step(4'b0100);
    checkOutput("sfx2 start", 6'd12, 1'b1, 2'd2, 1'b0);
    for (int k = 0; k < 4; k++) step(4'b0100);
    step(4'b0101);
    checkOutput("preempt", 6'd1, 1'b1, 2'd0, 1'b0);
    step(4'b1101);
    checkOutput("ignore low prio", 6'd1, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 40; k++) step(4'b0000);

    // Simultaneous rises, then a held trigger never starts later
    step(4'b0110);
    checkOutput("simul rise", 6'd5, 1'b1, 2'd1, 1'b0);
    for (int k = 0; k < 20; k++) step(4'b0110);
    checkOutput("held no start", 6'd0, 1'b0, 2'd0, 1'b0);
    step(4'b0000);

    // Disable mid-note, re-enable with trigger held
    step(4'b0010);
    checkOutput("pre-disable", 6'd5, 1'b1, 2'd1, 1'b0);
    step(4'b0010);
    step(4'b0010);
    applyStimulus(1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 3'd0, 6'd0, 6'd0);
    checkOutput("disabled", 6'd0, 1'b0, 2'd0, 1'b0);
    applyStimulus(1'b0, 1'b0, 4'b0010, 1'b0, 2'd0, 3'd0, 6'd0, 6'd0);
    for (int k = 0; k < 3; k++) step(4'b0010);
    checkOutput("reenable held", 6'd0, 1'b0, 2'd0, 1'b0);
    step(4'b0000);

    // Reset mid-effect, table survives
    step(4'b0001);
    checkOutput("pre-reset", 6'd1, 1'b1, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) step(4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 3'd0, 6'd0, 6'd0);
    checkOutput("mid reset", 6'd0, 1'b0, 2'd0, 1'b0);
    step(4'b0000);
    step(4'b0010);
    checkOutput("post reset play", 6'd5, 1'b1, 2'd1, 1'b0);

    // Write to the sounding entry leaves the current note alone
    applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1, 2'd1, 3'd0, 6'd33, 6'd2);
    checkOutput("write sounding", 6'd5, 1'b1, 2'd1, 1'b0);
    for (int k = 0; k < 20; k++) step(4'b0000);
    step(4'b0010);
    checkOutput("new entry used", 6'd33, 1'b1, 2'd1, 1'b0);
    for (int k = 0; k < 20; k++) step(4'b0000);

    // Randomized traffic against the model
    r_en = 1'b1;
    r_trig = '0;
    for (int k = 0; k < 3000; k++) begin
      if (r_en ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 7) == 0)) r_en = ~r_en;
      if ($urandom_range(0, 5) == 0) r_trig = r_trig ^ (4'b0001 << $urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 499) == 0), r_en, r_trig,
                    ($urandom_range(0, 24) == 0), 2'($urandom_range(0, 3)),
                    3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)),
                    6'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfx_sequencer.md
Name: sfx_sequencer

Overview:
Parametrised sound-effect sequencer that drives the buzzer tone generator with a note code. It supports NUM_SFX independently programmable effects, each a list of up to MAX_NOTES (note, duration) entries held in a writable table. Effects start on trigger rising edges, are arbitrated by fixed priority, and can be pre-empted by a higher-priority effect. The duration tick is generated inside the clk domain; there is no derived clock. It sits between the game logic (hit, pause and win events) and the buzzer note decoder.

Parameters:
NOTE_W, 6, width of note code; 0 = silence/rest
LEN_W, 6, width of per-note duration in ticks
MAX_NOTES, 8, entries per effect (power of two)
NUM_SFX, 4, number of effects/trigger channels (power of two, >=2)
TICK_DIV, 262144, clk cycles per duration tick (>=2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enabled  in  1  sound enable; low forces silence
trigger  in  NUM_SFX  per-effect request, rising-edge sensitive
cfg_we  in  1  table write strobe
cfg_sfx  in  $clog2(NUM_SFX)  effect index to write
cfg_idx  in  $clog2(MAX_NOTES)  entry index to write
cfg_note  in  NOTE_W  note code to write
cfg_len  in  LEN_W  duration to write; 0 = end-of-effect marker
note  out  NOTE_W  current note code to buzzer
busy  out  1  effect playing
active_id  out  $clog2(NUM_SFX)  index of playing effect (0 when idle)
done  out  1  one-cycle pulse on natural completion

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high.
- Reset: note=0, busy=0, active_id=0, done=0. Tick counter, entry pointer, remaining count and trigger history are cleared to 0. Table contents are NOT cleared. Reset mid-effect silences the output on the next edge.
- Table: NUM_SFX*MAX_NOTES entries of {note, len}. A write occurs on the clk edge when cfg_we=1. Entries are read only at effect start or entry advance. A write to the entry currently sounding does not alter the current note.
- Edge detect: trig_q <= trigger every cycle, including when enabled=0. rise = trigger & ~trig_q.
- Arbitration: the lowest set index of rise wins. When idle, the winner starts. When busy, the winner starts only if its index < active_id (pre-emption). A rise with index >= active_id is dropped and is not queued.
- Start, decided at edge N where the rise is seen: on that edge active_id=winner, pointer=0, tick counter=0, and entry 0 is loaded.
  - If len0 != 0: busy=1, note=note0, remaining=len0. Latency from trigger high to note valid is 1 clk.
  - If len0 == 0: the effect is empty; busy stays 0, note=0, no done pulse.
- Tick: the counter runs 0..TICK_DIV-1 only while busy. tick is asserted when counter==TICK_DIV-1, then the counter wraps to 0.
- Advance: on tick, remaining decrements. When remaining==1 at a tick, pointer+1 is loaded instead. Each entry therefore sounds for exactly len*TICK_DIV clk cycles.
- End: advance past index MAX_NOTES-1, or loading an entry with len==0, ends the effect. On that edge: note=0, busy=0, active_id=0, done=1 for one cycle. There is no pointer wrap.
- note==0 with len!=0 is a rest inside the effect, not a terminator.
- Simultaneous end and rise on the same edge: the new start wins. busy stays 1 and done still pulses.
- Pre-emption: no done pulse for the aborted effect. The new effect starts as above and the tick counter restarts.
- enabled=0: on the next edge note=0, busy=0, active_id=0, done=0, and rises are ignored. A trigger held high across enabled rising does not fire.

Test Plan:
- TICK_DIV=4. Write sfx1 = {(5,2),(9,1),(0,0 end)}. Pulse trigger[1] at cycle 10 -> note=5 from cycle 11 for 8 cycles, note=9 for 4 cycles, then note=0, busy=0, done=1 for 1 cycle.
- Fill all 8 entries of sfx0 with len=1 and notes 1..8. Trigger -> notes 1..8, 4 cycles each; ends after 32 cycles with no wrap.
- sfx2 playing, rise trigger[0] -> next edge active_id=0, sfx0 entry 0 sounds, no done. While sfx0 plays, rise trigger[3] -> ignored.
- Rises on trigger[1] and trigger[2] in the same cycle while idle -> active_id=1. Trigger[2] held high afterwards never starts sfx2.
- Deassert enabled mid-note -> next edge note=0, busy=0. Raise enabled with trigger still high -> no start. Assert reset mid-effect -> all outputs 0, and the table still plays correctly on the next trigger.
- Entry 0 of sfx3 has len=0; trigger[3] -> busy stays 0, done stays 0. A cfg write to the sounding entry during playback leaves the current note unchanged.
